max_pool_2x2: RTL and testbench
===============================

# max_pool_2x2

Streaming 2x2, stride-2 max-pooling stage that sits directly downstream of each layer-1 convolution filter in the LeNet-5 pipeline. It consumes one 28x28 signed feature map in raster order over an AXI-stream-style handshake and emits the 14x14 pooled map in raster order. It buffers one half-width row of partial maxima, so no frame buffer is needed. One instance is required per feature map (six for layer 1).

## Interface
- DATA_WIDTH, 16: signed fixed-point sample width.
- IMG_WIDTH, 28: input columns; must be even (elaboration assertion).
- IMG_HEIGHT, 28: input rows; must be even (elaboration assertion).
- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets the block on the clock edge).
- s_tvalid  in  1  input sample valid.
- s_tready  out  1  input ready.
- s_tdata  in  DATA_WIDTH  input sample (signed).
- s_tlast  in  1  marks the final sample of the input frame.
- m_tvalid  out  1  output sample valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  DATA_WIDTH  pooled sample (signed).
- m_tlast  out  1  marks the final pooled sample of the frame.
- busy  out  1  a frame is in progress.
- frame_err  out  1  sticky flag for a framing error; cleared only by reset.

## Operation
- Counters: col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1). They advance on each input beat (s_tvalid & s_tready). col wraps to 0 and row increments; after the final pixel both return to 0.
- Even col, any row: the sample is held in hold_reg.
- Odd col, even row: line_buf[col/2] <= max(hold_reg, sample).
- Odd col, odd row ("produce beat"): the output register loads max(hold_reg, sample, line_buf[col/2]).
  - m_tvalid is set.
  - m_tlast = (row==IMG_HEIGHT-1 && col==IMG_WIDTH-1).
- All comparisons are signed two's-complement. Ties keep either operand, since the values are equal. There is no width growth.
- line_buf holds IMG_WIDTH/2 entries of DATA_WIDTH. It is written on even rows and read on odd rows, at the same index during the same row pair.
- Output register: single entry.
  - It clears m_tvalid when m_tvalid & m_tready, unless a produce beat reloads it in the same cycle.
  - A simultaneous drain and load results in m_tvalid staying 1 with the new data.
- s_tready = reset & !(produce_slot & m_tvalid & !m_tready), where produce_slot = odd row & odd col.
  - Non-producing beats are always accepted, so the block throttles input only when it would overwrite unconsumed output.
- busy:
  - Sets on the first accepted beat of a frame.
  - Clears on the cycle the m_tlast beat is accepted downstream.
- Framing check:
  - s_tlast on a beat that is not the final pixel: set frame_err, drop that beat from pooling, and reset col/row to 0 (resync). A pending output in the output register is still delivered.
  - Final pixel without s_tlast: set frame_err. Processing completes normally and the counters wrap.
- Reset (synchronous, reset==0), applied on the next edge including mid-frame:
  - Outputs: m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, frame_err=0.
  - Internal: counters=0, hold_reg=0. line_buf contents need not be cleared, because they are always rewritten before being read.
  - s_tready is 0 while reset is asserted.

## Timing
- Throughput: 1 input sample per cycle when m_tready is held high. This includes back-to-back frames with no idle cycle.
- Latency: m_tvalid rises on the cycle after the producing beat is accepted. Output i is the beat following input pixel (2r+1, 2c+1).
- Output rate: 196 outputs per 784 inputs. Outputs occur only during odd rows, one every 2 input beats.
- m_tdata and m_tlast hold stable while m_tvalid & !m_tready.
- s_tready depends combinationally on m_tready. This is the only combinational input-to-output path.

## Test plan
- Ramp frame (s_tdata = row*28+col), m_tready=1, s_tvalid=1 → 196 outputs with out[r][c] = (2r+1)*28+2c+1; m_tlast only on the 196th (value 783); frame_err=0; 784 input cycles with no stall.
- Signed check: all pixels -32768 except pixel (1,0) = -1 and pixel (26,27) = 0x7FFF → out[0][0] = -1, out[13][13] = 32767, all others -32768.
- Backpressure: ramp frame with m_tready toggling pseudo-randomly at 50% → identical 196-value sequence, no drop or duplication; s_tready low only on produce slots with a full output register.
- Early s_tlast on input beat 100 → frame_err=1 on the next cycle and counters at 0; a following clean ramp frame produces the correct 196 outputs.
- Reset low for 1 cycle after 300 accepted beats → m_tvalid=0, busy=0, frame_err=0 after the edge; the next full frame is correct.
- Two back-to-back ramp frames, second offset by +1000 → 392 outputs, second-frame out[0][0]=1029; busy stays 1 across the boundary; m_tlast on outputs 196 and 392.

Source files
------------

// File: rtl/max_pool_2x2.sv
`default_nettype none
// ============================================================================
// Module   : max_pool_2x2
// Brief    : Streaming 2x2 / stride-2 signed max-pooling stage. It takes a
//            raster-order feature map over a valid/ready handshake and keeps
//            one half-width row of partial maxima, so no frame buffer is used.
// Revision : 1.0 - initial release
// ============================================================================
module max_pool_2x2 #(
   parameter int DATA_WIDTH = 16,
   parameter int IMG_WIDTH  = 28,
   parameter int IMG_HEIGHT = 28
) (
   input  logic                  clock,
   input  logic                  reset,      // active-low, synchronous
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic [DATA_WIDTH-1:0] s_tdata,
   input  logic                  s_tlast,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tlast,
   output logic                  busy,
   output logic                  frame_err
);

   localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
   localparam int LB_DEPTH = IMG_WIDTH / 2;
   localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_HEIGHT - 1);

   // Odd geometries cannot be pooled 2x2 without leftovers; refuse them.
   generate
      if ((IMG_WIDTH % 2) != 0) begin : g_bad_width
         $error("max_pool_2x2: IMG_WIDTH must be even");
      end
      if ((IMG_HEIGHT % 2) != 0) begin : g_bad_height
         $error("max_pool_2x2: IMG_HEIGHT must be even");
      end
   endgenerate

   // Signed two's-complement maximum, no width growth.
   function automatic logic [DATA_WIDTH-1:0] f_max(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   logic [CW-1:0]         r_col;
   logic [RW-1:0]         r_row;
   logic [DATA_WIDTH-1:0] r_hold;
   logic [DATA_WIDTH-1:0] r_line_buf [0:LB_DEPTH-1];
   logic                  r_m_tvalid;
   logic [DATA_WIDTH-1:0] r_m_tdata;
   logic                  r_m_tlast;
   logic                  r_busy;
   logic                  r_frame_err;

   logic                  w_produce_slot;
   logic                  w_beat;
   logic                  w_last_col;
   logic                  w_last_row;
   logic                  w_last_pix;
   logic                  w_early_last;
   logic                  w_pool_beat;
   logic                  w_produce;
   logic                  w_drain;
   logic [CW-2:0]         w_lb_idx;
   logic [DATA_WIDTH-1:0] w_pair_max;
   logic [DATA_WIDTH-1:0] w_quad_max;

   assign w_produce_slot = r_row[0] & r_col[0];
   // Stall only when a produce beat would overwrite an unconsumed output.
   assign s_tready       = reset & ~(w_produce_slot & r_m_tvalid & ~m_tready);
   assign w_beat         = s_tvalid & s_tready;
   assign w_last_col     = (r_col == c_COL_LAST);
   assign w_last_row     = (r_row == c_ROW_LAST);
   assign w_last_pix     = w_last_col & w_last_row;
   assign w_early_last   = s_tlast & ~w_last_pix;
   assign w_pool_beat    = w_beat & ~w_early_last;
   assign w_produce      = w_pool_beat & w_produce_slot;
   assign w_drain        = r_m_tvalid & m_tready;
   assign w_lb_idx       = r_col[CW-1:1];
   assign w_pair_max     = f_max(r_hold, s_tdata);
   assign w_quad_max     = f_max(w_pair_max, r_line_buf[w_lb_idx]);

   // Raster position, even-column hold register and sticky framing error.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_col       <= '0;
         r_row       <= '0;
         r_hold      <= '0;
         r_frame_err <= 1'b0;
      end else if (w_beat) begin
         if (w_early_last) begin
            // Premature end of frame: drop the beat and resync to pixel 0.
            r_col       <= '0;
            r_row       <= '0;
            r_frame_err <= 1'b1;
         end else begin
            if (!r_col[0]) begin
               r_hold <= s_tdata;
            end
            if (w_last_col) begin
               r_col <= '0;
               r_row <= w_last_row ? '0 : r_row + RW'(1);
            end else begin
               r_col <= r_col + CW'(1);
            end
            if (w_last_pix && !s_tlast) begin
               r_frame_err <= 1'b1;
            end
         end
      end
   end

   // Partial row maxima: written on even rows, consumed on the following odd row.
   always_ff @(posedge clock) begin
      if (w_pool_beat && r_col[0] && !r_row[0]) begin
         r_line_buf[w_lb_idx] <= w_pair_max;
      end
   end

   // Single-entry output register; a reload in the drain cycle keeps valid high.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_m_tvalid <= 1'b0;
         r_m_tdata  <= '0;
         r_m_tlast  <= 1'b0;
      end else if (w_produce) begin
         r_m_tvalid <= 1'b1;
         r_m_tdata  <= w_quad_max;
         r_m_tlast  <= w_last_pix;
      end else if (w_drain) begin
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
      end
   end

   // Frame-in-progress flag; a new frame's first beat wins over the old tlast drain.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_busy <= 1'b0;
      end else if (w_beat && w_early_last) begin
         r_busy <= 1'b0;
      end else if (w_beat) begin
         r_busy <= 1'b1;
      end else if (w_drain && r_m_tlast) begin
         r_busy <= 1'b0;
      end
   end

   assign m_tvalid  = r_m_tvalid;
   assign m_tdata   = r_m_tdata;
   assign m_tlast   = r_m_tlast;
   assign busy      = r_busy;
   assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_max_pool_2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_max_pool_2x2
// Brief    : Scoreboard bench for max_pool_2x2 with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_max_pool_2x2;

   logic        clock = 1'b0;
   logic        reset;
   logic        s_tvalid;
   logic        s_tready;
   logic [15:0] s_tdata;
   logic        s_tlast;
   logic        m_tvalid;
   logic        m_tready;
   logic [15:0] m_tdata;
   logic        m_tlast;
   logic        busy;
   logic        frame_err;

   max_pool_2x2 #(.DATA_WIDTH(16), .IMG_WIDTH(28), .IMG_HEIGHT(28)) dut (
      .clock(clock), .reset(reset),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
      .busy(busy), .frame_err(frame_err)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          out_cnt  = 0;
   logic [16:0] exp_q [$];   // {last, data}
   logic        bp_mode  = 1'b0;
   logic        bb_mon   = 1'b0;
   logic        bb_drop  = 1'b0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data;
   logic        prev_last;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Downstream ready: always high, or pseudo-random during backpressure.
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on every output handshake.
   always @(negedge clock) begin
      logic [16:0] e;
      if (reset) begin
         if (m_tvalid && m_tready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_output", {15'd0, m_tlast, m_tdata}, 32'hDEAD);
            end else begin
               e = exp_q.pop_front();
               check("out_data", {16'd0, m_tdata}, {16'd0, e[15:0]});
               check("out_last", {31'd0, m_tlast}, {31'd0, e[16]});
            end
         end
         if (prev_stall && m_tvalid) begin
            check("hold_data", {16'd0, m_tdata}, {16'd0, prev_data});
            check("hold_last", {31'd0, m_tlast}, {31'd0, prev_last});
         end
         if (!s_tready)
            check("stall_only_when_full", {31'd0, m_tvalid & ~m_tready}, 32'd1);
         if (bb_mon && !busy) bb_drop = 1'b1;
      end
      prev_stall = reset & m_tvalid & ~m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
   end

   task automatic send_beat(input logic [15:0] d, input logic l);
      logic acc;
      int   guard;
      guard    = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      forever begin
         @(negedge clock);
         acc = s_tready;
         @(posedge clock);
         #1;
         if (acc) break;
         guard++;
         if (guard > 1000) begin
            $display("FAIL input_timeout: s_tready stuck low, expected accept");
            $fatal(1, "input handshake timeout");
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   // Expected ramp outputs for pooled rows [0, nrows), first ncols_last of final row.
   task automatic push_ramp(input int off, input int nrows, input int ncols_last);
      for (int r = 0; r < nrows; r++) begin
         for (int c = 0; c < 14; c++) begin
            if (r == nrows - 1 && c >= ncols_last) break;
            exp_q.push_back({1'(r == 13 && c == 13), 16'(off + (2*r+1)*28 + 2*c + 1)});
         end
      end
   endtask

   task automatic ramp_frame(input int off, input logic mon);
      for (int k = 0; k < 784; k++) begin
         send_beat(16'(off + k), k == 783);
         if (mon && k == 0) bb_mon = 1'b1;
      end
   endtask

   task automatic drain(input string name);
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 3000) begin
         @(posedge clock);
         #1;
         guard++;
      end
      check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      int t0;
      int n0;
      reset    = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tlast  = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("rst_m_tdata",  {16'd0, m_tdata},  32'd0);
      check("rst_m_tlast",  {31'd0, m_tlast},  32'd0);
      check("rst_busy",     {31'd0, busy},     32'd0);
      check("rst_frame_err",{31'd0, frame_err},32'd0);
      check("rst_s_tready", {31'd0, s_tready}, 32'd0);
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Ramp frame at full rate.
      push_ramp(0, 14, 14);
      t0 = cyc;
      n0 = out_cnt;
      ramp_frame(0, 1'b0);
      check("ramp_cycles", 32'(cyc - t0), 32'd784);
      drain("ramp");
      check("ramp_count", 32'(out_cnt - n0), 32'd196);
      check("ramp_busy_end", {31'd0, busy}, 32'd0);
      check("ramp_frame_err", {31'd0, frame_err}, 32'd0);

      // Signed extremes.
      for (int i = 0; i < 196; i++) begin
         if (i == 0)        exp_q.push_back({1'b0, 16'hFFFF});
         else if (i == 195) exp_q.push_back({1'b1, 16'h7FFF});
         else               exp_q.push_back({1'b0, 16'h8000});
      end
      for (int k = 0; k < 784; k++) begin
         if (k == 28)       send_beat(16'hFFFF, 1'b0);
         else if (k == 755) send_beat(16'h7FFF, 1'b0);
         else               send_beat(16'h8000, k == 783);
      end
      drain("signed");

      // Backpressure.
      bp_mode = 1'b1;
      push_ramp(0, 14, 14);
      n0 = out_cnt;
      ramp_frame(0, 1'b0);
      drain("bp");
      bp_mode = 1'b0;
      check("bp_count", 32'(out_cnt - n0), 32'd196);

      // Early tlast on beat 100: 14 outputs of pooled row 0, 8 of pooled row 1.
      push_ramp(0, 2, 8);
      for (int k = 0; k < 100; k++) send_beat(16'(k), 1'b0);
      send_beat(16'd100, 1'b1);
      @(negedge clock);
      check("early_frame_err", {31'd0, frame_err}, 32'd1);
      @(posedge clock);
      #1;
      push_ramp(0, 14, 14);
      ramp_frame(0, 1'b0);
      drain("resync");
      check("frame_err_sticky", {31'd0, frame_err}, 32'd1);

      // Mid-frame reset after 300 beats (pooled rows 0..4 already complete).
      push_ramp(0, 5, 14);
      for (int k = 0; k < 300; k++) send_beat(16'(k), 1'b0);
      check("pre_reset_queue", 32'(exp_q.size()), 32'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("midrst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("midrst_busy",     {31'd0, busy},     32'd0);
      check("midrst_frame_err",{31'd0, frame_err},32'd0);
      reset = 1'b1;
      push_ramp(0, 14, 14);
      ramp_frame(0, 1'b0);
      drain("post_reset");

      // Back-to-back frames, second offset by 1000.
      push_ramp(0, 14, 14);
      push_ramp(1000, 14, 14);
      check("b2b_second_first", {16'd0, exp_q[196][15:0]}, 32'd1029);
      n0 = out_cnt;
      bb_drop = 1'b0;
      ramp_frame(0, 1'b1);
      ramp_frame(1000, 1'b0);
      bb_mon = 1'b0;
      drain("b2b");
      check("b2b_count", 32'(out_cnt - n0), 32'd392);
      check("b2b_busy_held", {31'd0, bb_drop}, 32'd0);
      check("b2b_busy_end", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
